btn_ctrl: RTL and testbench

Multi-button input controller for the counter front panel. It generates the shared 1 ms clock-enable strobe from the system clock and synchronises N raw push-button inputs. Each button runs through its own press/release debounce state machine, clocked only on that strobe. It emits debounced levels plus one-cycle press/release pulses that drive the counter modules directly, with optional auto-repeat on held buttons.

---
 rtl/btn_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_btn_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_ctrl.sv
//==============================================================================
// Module   : btn_ctrl
// Purpose  : Multi-button front-panel input controller. Generates the shared
//            1 ms clock-enable strobe, synchronises N raw push buttons and
//            debounces each one with its own press/release state machine
//            that advances only on the strobe. Produces debounced levels and
//            one-cycle press/release pulses for the counter modules.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   N_BTN            number of buttons (1..8)
//   CLK_DIV          system clocks per 1 ms tick (>= 2)
//   STABLE_MS        consecutive equal samples needed to accept a change (2..15)
//   REPEAT_DELAY_MS  hold time before the first auto-repeat pulse (>= 1)
//   REPEAT_RATE_MS   interval between subsequent auto-repeat pulses (>= 1)
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   btn_in       in   raw asynchronous button inputs, 1 = pressed
//   ce1ms        out  one-clk strobe every CLK_DIV cycles
//   btn_level    out  debounced button state
//   btn_press    out  one-cycle pulse on accepted press (and on auto-repeat)
//   btn_release  out  one-cycle pulse on accepted release
//
// Build option
//   BTN_AUTOREPEAT_EN  when defined, a held button emits repeated btn_press
//                      pulses; when undefined the hold counter is not built
//                      and each accepted press yields exactly one pulse.
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module btn_ctrl #(
    parameter int N_BTN           = 4,
    parameter int CLK_DIV         = 50000,
    parameter int STABLE_MS       = 8,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic             ce1ms,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    //--------------------------------------------------------------------------
    // Elaboration-time parameter range check
    //--------------------------------------------------------------------------
    if (N_BTN < 1 || N_BTN > 8 || CLK_DIV < 2 || STABLE_MS < 2 ||
        STABLE_MS > 15 || REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1)
    begin : g_param_check
        $error("btn_ctrl: parameter out of range");
    end

    //--------------------------------------------------------------------------
    // Constants and types
    //--------------------------------------------------------------------------
    localparam int              DIV_W      = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]      C_DEB_LAST = 4'(STABLE_MS - 1);

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    //--------------------------------------------------------------------------
    // 1 ms prescaler. The strobe is registered, so it is high in the cycle
    // after the counter reaches its last value; with the counter at 0 in
    // cycle 0 the first strobe lands in cycle CLK_DIV.
    //--------------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             ce1ms_q;
    logic             ce1ms_d;

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        ce1ms_d   = 1'b0;
        if (div_cnt_q == C_DIV_LAST) begin
            div_cnt_d = '0;
            ce1ms_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            ce1ms_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ce1ms_q   <= ce1ms_d;
        end
    end

    assign ce1ms = ce1ms_q;

    //--------------------------------------------------------------------------
    // Two-flop synchronisers for the raw asynchronous inputs
    //--------------------------------------------------------------------------
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    //--------------------------------------------------------------------------
    // Per-button debounce state machines. Each one only moves on edges where
    // the 1 ms strobe is high; the pulse registers default low every cycle so
    // a pulse lasts exactly one clk.
    //--------------------------------------------------------------------------
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t     state_q;
        state_t     state_d;
        logic [3:0] deb_q;
        logic [3:0] deb_d;
        logic       level_q;
        logic       level_d;
        logic       press_q;
        logic       press_d;
        logic       rel_q;
        logic       rel_d;
        logic       smp;

        assign smp = sync2_q[i];

`ifdef BTN_AUTOREPEAT_EN
        localparam int               HOLD_W       = $clog2(REPEAT_DELAY_MS + 1);
        localparam logic [HOLD_W-1:0] C_REP_DELAY  = HOLD_W'(REPEAT_DELAY_MS);
        // A rate longer than the delay would need a negative reload; fall
        // back to zero so the repeat period is then the full delay.
        localparam logic [HOLD_W-1:0] C_REP_RELOAD =
            (REPEAT_RATE_MS >= REPEAT_DELAY_MS) ? '0
                                                : HOLD_W'(REPEAT_DELAY_MS - REPEAT_RATE_MS);

        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;
        logic [HOLD_W-1:0] hold_inc;

        // Saturating increment: the counter never wraps back to zero.
        assign hold_inc = (hold_q == {HOLD_W{1'b1}}) ? hold_q : hold_q + HOLD_W'(1);
`endif

        always_comb begin
            state_d = state_q;
            deb_d   = deb_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            hold_d  = hold_q;
`endif
            if (ce1ms_q) begin
                case (state_q)
                    S_RELEASED: begin
                        if (smp) begin
                            state_d = S_PRESS_WAIT;
                            deb_d   = 4'd1;
                        end
                    end
                    S_PRESS_WAIT: begin
                        if (!smp) begin
                            state_d = S_RELEASED;
                        end else if (deb_q == C_DEB_LAST) begin
                            // STABLE_MS-th consecutive high sample
                            state_d = S_HELD;
                            level_d = 1'b1;
                            press_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            hold_d  = '0;
`endif
                        end else begin
                            deb_d = deb_q + 4'd1;
                        end
                    end
                    S_HELD: begin
                        if (!smp) begin
                            state_d = S_RELEASE_WAIT;
                            deb_d   = 4'd1;
                        end else begin
`ifdef BTN_AUTOREPEAT_EN
                            if (hold_inc == C_REP_DELAY) begin
                                press_d = 1'b1;
                                hold_d  = C_REP_RELOAD;
                            end else begin
                                hold_d  = hold_inc;
                            end
`endif
                        end
                    end
                    S_RELEASE_WAIT: begin
                        // A rejected release returns to HELD with the hold
                        // count untouched, so repeats resume where they were.
                        if (smp) begin
                            state_d = S_HELD;
                        end else if (deb_q == C_DEB_LAST) begin
                            state_d = S_RELEASED;
                            level_d = 1'b0;
                            rel_d   = 1'b1;
                        end else begin
                            deb_d = deb_q + 4'd1;
                        end
                    end
                    default: begin
                        state_d = S_RELEASED;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= S_RELEASED;
                deb_q   <= 4'd0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                hold_q  <= '0;
`endif
            end else begin
                state_q <= state_d;
                deb_q   <= deb_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
`ifdef BTN_AUTOREPEAT_EN
                hold_q  <= hold_d;
`endif
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = rel_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_btn_ctrl.sv
//==============================================================================
// Module   : tb_btn_ctrl
// Purpose  : Self-checking bench for btn_ctrl with CLK_DIV=10, STABLE_MS=4,
//            REPEAT_DELAY_MS=20, REPEAT_RATE_MS=5, N_BTN=4. Directed steps
//            schedule the expected press/release pulses (kind, button, cycle)
//            into a queue; a monitor pops and compares every pulse seen.
//            Cycle k is the period after the k-th rising edge following reset
//            release, so ticks (ce1ms high) fall on cycles 10, 20, 30...
//            Inputs change at cycle 10*t+3 so the first tick to see the new
//            value is tick t+1.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_btn_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] btn_in;
    logic       ce1ms;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int  n_total = 0;
    int  n_bad   = 0;
    int  cyc;
    bit  mon_en  = 1'b0;

    typedef struct {
        bit rel;
        int btn;
        int cyc;
    } ev_t;

    ev_t q[$];

    btn_ctrl #(
        .N_BTN           (4),
        .CLK_DIV         (10),
        .STABLE_MS       (4),
        .REPEAT_DELAY_MS (20),
        .REPEAT_RATE_MS  (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .ce1ms       (ce1ms),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input bit rel, input int b, input int c);
        ev_t e;
        e.rel = rel;
        e.btn = b;
        e.cyc = c;
        q.push_back(e);
    endtask

    // Pop the earliest scheduled pulse of this kind/button and compare its
    // cycle with the cycle the pulse was actually seen (-1 = not scheduled).
    task automatic match(input bit rel, input int b);
        int idx   = -1;
        int exp_c = -1;
        foreach (q[k]) begin
            if (idx < 0 && q[k].rel == rel && q[k].btn == b) begin
                idx   = k;
                exp_c = q[k].cyc;
            end
        end
        if (idx >= 0) q.delete(idx);
        check($sformatf("%s%0d_cycle", rel ? "release" : "press", b), cyc, exp_c);
    endtask

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            check($sformatf("ce1ms_c%0d", cyc), ce1ms, (cyc != 0 && cyc % 10 == 0));
            for (int b = 0; b < 4; b++) begin
                if (btn_press[b])   match(1'b0, b);
                if (btn_release[b]) match(1'b1, b);
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 4'b0000;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ce1ms",   ce1ms,       0);
        check("rst_level",   btn_level,   0);
        check("rst_press",   btn_press,   0);
        check("rst_release", btn_release, 0);

        rst    = 1'b0;
        mon_en = 1'b1;

        // Idle: monitor checks strobe spacing, no pulses are scheduled
        wait_cyc(100);
        check("idle_level", btn_level, 0);

        // Button 0 pressed steadily: ticks 11..14 high, accepted at tick 14
        wait_cyc(103);
        btn_in[0] = 1'b1;
        expect_ev(1'b0, 0, 141);
        wait_cyc(140);
        check("lvl0_before_accept", btn_level[0], 0);
        wait_cyc(141);
        check("lvl0_after_accept", btn_level[0], 1);

        // Button 1 bounces 1-0-1 over ticks 16..18, then stays high
        wait_cyc(153);
        btn_in[1] = 1'b1;
        expect_ev(1'b0, 1, 211);
        wait_cyc(163);
        btn_in[1] = 1'b0;
        wait_cyc(173);
        btn_in[1] = 1'b1;
        wait_cyc(201);
        check("lvl1_three_highs", btn_level[1], 0);
        wait_cyc(211);
        check("lvl1_accepted", btn_level[1], 1);

        // Two-tick low glitch on button 0: no release, no extra press
        wait_cyc(223);
        btn_in[0] = 1'b0;
        wait_cyc(243);
        btn_in[0] = 1'b1;
        wait_cyc(260);
        check("lvl0_after_glitch", btn_level[0], 1);

        // Release buttons 0 and 1 together: both release on tick 30
        wait_cyc(263);
        btn_in[1:0] = 2'b00;
        expect_ev(1'b1, 0, 301);
        expect_ev(1'b1, 1, 301);
        wait_cyc(300);
        check("lvl_before_release", btn_level, 4'b0011);
        wait_cyc(301);
        check("lvl_after_release", btn_level, 4'b0000);

        // Button 2 held for 40 ticks (32..71): accepted at tick 35
        wait_cyc(313);
        btn_in[2] = 1'b1;
        expect_ev(1'b0, 2, 351);
`ifdef BTN_AUTOREPEAT_EN
        expect_ev(1'b0, 2, 551);
        expect_ev(1'b0, 2, 601);
        expect_ev(1'b0, 2, 651);
        expect_ev(1'b0, 2, 701);
`endif
        wait_cyc(713);
        btn_in[2] = 1'b0;
        expect_ev(1'b1, 2, 751);
        wait_cyc(760);
        check("lvl_after_hold", btn_level, 0);

        // Button 3 accepted, then reset asserted while still held
        wait_cyc(773);
        btn_in[3] = 1'b1;
        expect_ev(1'b0, 3, 811);
        wait_cyc(815);
        check("lvl3_before_reset", btn_level[3], 1);
        check("pending_before_reset", q.size(), 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_level",   btn_level,   0);
        check("async_rst_ce1ms",   ce1ms,       0);
        check("async_rst_press",   btn_press,   0);
        check("async_rst_release", btn_release, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Still held: needs four fresh ticks (10, 20, 30, 40)
        expect_ev(1'b0, 3, 41);
        wait_cyc(40);
        check("lvl3_fresh_before", btn_level[3], 0);
        wait_cyc(41);
        check("lvl3_fresh_after", btn_level[3], 1);
        wait_cyc(60);
        check("pending_at_end", q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
